// File: rtl/instruction_cache_pkg.sv
// instruction_cache_pkg: shared word type plus the cache FSM states and line geometry.
package rv32i_types;
   typedef logic [31:0] rv32i_word;
endpackage

package icache_types;
   typedef enum logic {IDLE, FETCH} state_t;
   localparam int LINE_W = 256;
   localparam int WSEL_W = 3;
endpackage

// File: rtl/instruction_cache_array.sv
// cache_array: per-set storage with asynchronous read and synchronous write; optional clear on reset.
module cache_array #(
   parameter int S_INDEX = 3,
   parameter int WIDTH = 1,
   parameter bit RESET = 1'b0
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  logic [S_INDEX-1:0] index,
   input  logic [WIDTH-1:0]   din,
   output logic [WIDTH-1:0]   dout
);
   logic [WIDTH-1:0] mem [2**S_INDEX];
   assign dout = mem[index];
   always_ff @(posedge clk)
      if (RESET && rst) mem <= '{default: '0};
      else if (we) mem[index] <= din;
endmodule

// File: rtl/instruction_cache.sv
// instruction_cache: 2-way read-only I-cache, combinational hits, single-burst line fill on miss.
module instruction_cache
   import rv32i_types::*, icache_types::*;
#(
   parameter int S_OFFSET = 5,
   parameter int S_INDEX = 3
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_read,
   input  rv32i_word         inst_addr,
   output logic              inst_resp,
   output rv32i_word         inst_rdata,
   output logic              pmem_read,
   output rv32i_word         pmem_address,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);
   localparam int S_TAG = 32 - S_OFFSET - S_INDEX;
   state_t state;
   logic [31-S_OFFSET:0] miss_addr;
   logic [S_TAG-1:0] atag, mtag;
   logic [S_INDEX-1:0] aidx, midx, ridx;
   logic [WSEL_W-1:0] word;
   logic [LINE_W-1:0] data [2];
   logic [LINE_W-1:0] line;
   logic [S_TAG-1:0] tag [2];
   logic [1:0] valid, way_hit;
   logic lru, victim, hit, fill, unused_bits;
   genvar w;
   assign atag = inst_addr[31:S_OFFSET+S_INDEX];
   assign aidx = inst_addr[S_OFFSET+S_INDEX-1:S_OFFSET];
   assign word = inst_addr[S_OFFSET-1:2];
   assign unused_bits = ^inst_addr[1:0];
   assign mtag = miss_addr[31-S_OFFSET:S_INDEX];
   assign midx = miss_addr[S_INDEX-1:0];
   // Lookups only happen in IDLE and fills only in FETCH, so one index serves both.
   assign ridx = (state == FETCH) ? midx : aidx;
   assign way_hit = {valid[1] && tag[1] == atag, valid[0] && tag[0] == atag};
   assign hit = inst_read && state == IDLE && |way_hit;
   assign line = way_hit[0] ? data[0] : data[1];
   assign inst_resp = hit;
   assign inst_rdata = hit ? line[{word, 5'b0} +: 32] : '0;
   assign victim = !valid[0] ? 1'b0 : !valid[1] ? 1'b1 : lru;
   assign fill = state == FETCH && pmem_resp && !rst;
   assign pmem_address = {miss_addr, {S_OFFSET{1'b0}}};
   for (w = 0; w < 2; w++) begin : g_way
      logic we;
      assign we = fill && victim == 1'(w);
      cache_array #(.S_INDEX(S_INDEX), .WIDTH(LINE_W)) u_data (
         .clk(clk), .rst(rst), .we(we), .index(ridx), .din(pmem_rdata), .dout(data[w]));
      cache_array #(.S_INDEX(S_INDEX), .WIDTH(S_TAG)) u_tag (
         .clk(clk), .rst(rst), .we(we), .index(ridx), .din(mtag), .dout(tag[w]));
      cache_array #(.S_INDEX(S_INDEX), .WIDTH(1), .RESET(1'b1)) u_valid (
         .clk(clk), .rst(rst), .we(we), .index(ridx), .din(1'b1), .dout(valid[w]));
   end
   cache_array #(.S_INDEX(S_INDEX), .WIDTH(1), .RESET(1'b1)) u_lru (
      .clk(clk), .rst(rst), .we(hit || fill), .index(ridx),
      .din(fill ? ~victim : way_hit[0]), .dout(lru));
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         miss_addr <= '0;
         pmem_read <= 1'b0;
      end else if (state == IDLE) begin
         if (inst_read && !hit) begin
            state <= FETCH;
            miss_addr <= inst_addr[31:S_OFFSET];
            pmem_read <= 1'b1;
         end
      end else if (pmem_resp) begin
         state <= IDLE;
         pmem_read <= 1'b0;
      end
endmodule

// File: tb/tb_instruction_cache.sv
// tb_instruction_cache: directed and random fetches checked against a set/way/LRU reference model.
module tb_instruction_cache;
   logic clk = 1'b0;
   logic rst, inst_read, inst_resp, pmem_read, pmem_resp;
   logic [31:0] inst_addr, inst_rdata, pmem_address;
   logic [255:0] pmem_rdata;
   int checks = 0, errors = 0;
   bit mv [8][2];
   logic [23:0] mt [8][2];
   int mlru [8];
   bit h;

   always #5 clk = ~clk;

   instruction_cache dut (
      .clk(clk), .rst(rst), .inst_read(inst_read), .inst_addr(inst_addr),
      .inst_resp(inst_resp), .inst_rdata(inst_rdata), .pmem_read(pmem_read),
      .pmem_address(pmem_address), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp));

   // Memory contents: every word holds its own byte address xor 0x7F.
   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[31:2], 2'b00} ^ 32'h0000_007F;
   endfunction

   function automatic logic [255:0] line_of(input logic [31:0] a);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[32*i +: 32] = word_of({a[31:5], 5'b0} + 32'(4 * i));
      return l;
   endfunction

   function automatic int find_way(input logic [31:0] a);
      for (int i = 0; i < 2; i++) if (mv[a[7:5]][i] && mt[a[7:5]][i] == a[31:8]) return i;
      return -1;
   endfunction

   task automatic model_reset;
      for (int s = 0; s < 8; s++) begin
         mv[s][0] = 1'b0;
         mv[s][1] = 1'b0;
         mlru[s] = 0;
      end
   endtask

   task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", t, o, e);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic access(input logic [31:0] a, input int lat, output bit was_hit);
      int w, v, s;
      s = int'(a[7:5]);
      inst_read = 1'b1;
      inst_addr = a;
      w = find_way(a);
      was_hit = (w >= 0);
      @(negedge clk);
      chk("resp", 32'(inst_resp), 32'(was_hit));
      chk("pmem_read_idle", 32'(pmem_read), 0);
      if (!was_hit) begin
         chk("rdata_miss", inst_rdata, 0);
         tick;
         for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            chk("fetch_read", 32'(pmem_read), 1);
            chk("fetch_addr", pmem_address, {a[31:5], 5'b0});
            chk("fetch_resp", 32'(inst_resp), 0);
            if (k == lat) begin
               pmem_resp = 1'b1;
               pmem_rdata = line_of(a);
            end
            tick;
         end
         pmem_resp = 1'b0;
         pmem_rdata = '0;
         v = !mv[s][0] ? 0 : !mv[s][1] ? 1 : mlru[s];
         mv[s][v] = 1'b1;
         mt[s][v] = a[31:8];
         w = v;
         @(negedge clk);
         chk("resp_after_fill", 32'(inst_resp), 1);
         chk("pmem_read_drop", 32'(pmem_read), 0);
      end
      chk("rdata", inst_rdata, word_of(a));
      mlru[s] = 1 - w;
      tick;
   endtask

   initial begin
      rst = 1'b1;
      inst_read = 1'b0;
      inst_addr = '0;
      pmem_resp = 1'b0;
      pmem_rdata = '0;
      repeat (2) tick;
      rst = 1'b0;
      model_reset;
      @(negedge clk);
      chk("rst_resp", 32'(inst_resp), 0);
      chk("rst_pmem_read", 32'(pmem_read), 0);
      chk("rst_pmem_addr", pmem_address, 0);
      chk("rst_rdata", inst_rdata, 0);
      tick;

      access(32'h0000_006C, 3, h);
      chk("cold_miss", 32'(h), 0);
      access(32'h0000_0064, 1, h);
      chk("same_line_hit", 32'(h), 1);
      chk("word1", word_of(32'h64), 32'h0000_001B);

      access(32'h0000_1060, 2, h);
      chk("conflict_miss", 32'(h), 0);
      access(32'h0000_0060, 1, h);
      chk("hit_60", 32'(h), 1);
      access(32'h0000_2060, 2, h);
      chk("miss_2060", 32'(h), 0);
      access(32'h0000_0060, 1, h);
      chk("hit_60_kept", 32'(h), 1);
      access(32'h0000_1060, 2, h);
      chk("evicted_1060", 32'(h), 0);

      inst_read = 1'b0;
      inst_addr = 32'h0000_0060;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_resp", 32'(inst_resp), 0);
         chk("idle_rdata", inst_rdata, 0);
         chk("idle_pmem_read", 32'(pmem_read), 0);
         tick;
      end

      access(32'h0000_3084, 10, h);
      chk("long_stall_miss", 32'(h), 0);

      rst = 1'b1;
      tick;
      rst = 1'b0;
      model_reset;
      inst_read = 1'b1;
      inst_addr = 32'h0000_0060;
      @(negedge clk);
      chk("mid_miss_resp", 32'(inst_resp), 0);
      tick;
      @(negedge clk);
      chk("mid_fetch1", 32'(pmem_read), 1);
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      inst_read = 1'b0;
      @(negedge clk);
      chk("abort_pmem_read", 32'(pmem_read), 0);
      chk("abort_addr", pmem_address, 0);
      chk("abort_resp", 32'(inst_resp), 0);
      pmem_resp = 1'b1;
      pmem_rdata = line_of(32'h60);
      tick;
      pmem_resp = 1'b0;
      pmem_rdata = '0;
      @(negedge clk);
      chk("late_resp_ignored", 32'(pmem_read), 0);
      tick;
      access(32'h0000_006C, 2, h);
      chk("reaccess_miss", 32'(h), 0);

      for (int i = 0; i < 80; i++) begin
         logic [31:0] a;
         a = {24'($urandom_range(0, 2)) * 24'h000011, 8'($urandom)};
         if ($urandom_range(0, 7) == 0) begin
            inst_read = 1'b0;
            inst_addr = a;
            @(negedge clk);
            chk("rand_idle", 32'(inst_resp), 0);
            tick;
         end
         access(a, int'($urandom_range(1, 4)), h);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
